// File: rtl/stage_buf.sv
// Elastic pipeline-stage buffer: a small FIFO between two pipeline stages with
// optional same-cycle pass-through when empty and a writeback-driven flush.
module stage_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter bit BYPASS = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       up_valid,
    input  logic [DATA_W-1:0]          up_bus,
    output logic                       up_allowin,
    output logic                       dn_valid,
    output logic [DATA_W-1:0]          dn_bus,
    input  logic                       dn_allowin,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int MEM_N = (DEPTH > 1) ? DEPTH : 2;

    logic [DATA_W-1:0] mem_q [MEM_N];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic full_w, empty_w, bypass_now;
    logic push, pop, store;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_w    = (count_q == '0);
    assign full_w     = (count_q == CNT_W'(DEPTH));
    assign bypass_now = BYPASS && empty_w;

    // Handshake: a beat transfers on a side when its valid and allowin are both
    // high at the rising edge. up_allowin depends only on stored state, flush and
    // dn_allowin, never on up_valid/up_bus, so stages can be chained freely.
    assign up_allowin = !flush && (!full_w || dn_allowin);

    always_comb begin
        dn_valid = 1'b0;
        dn_bus   = '0;
        if (!reset) begin
            if (bypass_now) begin
                dn_valid = up_valid && !flush;
                dn_bus   = up_bus;
            end else if (!empty_w && !flush) begin
                dn_valid = 1'b1;
                dn_bus   = mem_q[rd_ptr_q];
            end
        end
    end

    // A bypassed beat is consumed downstream in the same cycle, so it is never written.
    assign push  = up_valid && up_allowin;
    assign pop   = dn_valid && dn_allowin && !empty_w;
    assign store = push && !(bypass_now && dn_allowin);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({store, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally unreset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (store && !reset) mem_q[wr_ptr_q] <= up_bus;
    end

    assign count = count_q;
    assign full  = full_w;
    assign empty = empty_w;

endmodule

// File: tb/tb_stage_buf.sv
// Directed and randomized-backpressure bench for stage_buf across several
// DEPTH/BYPASS configurations.
module tb_stage_buf;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Directed instances share their inputs.
    logic       up_valid = 1'b0;
    logic [7:0] up_bus = '0;
    logic       dn_allowin = 1'b0;
    logic       flush = 1'b0;

    logic       a_up_allowin, a_dn_valid, a_full, a_empty;
    logic [7:0] a_dn_bus;
    logic [1:0] a_count;
    logic       c_up_allowin, c_dn_valid, c_full, c_empty;
    logic [7:0] c_dn_bus;
    logic [1:0] c_count;
    logic       b_up_allowin, b_dn_valid, b_full, b_empty;
    logic [7:0] b_dn_bus;
    logic [1:0] b_count;

    stage_buf #(.DATA_W(8), .DEPTH(2), .BYPASS(1'b0)) u_a (
        .clk(clk), .reset(reset), .up_valid(up_valid), .up_bus(up_bus),
        .up_allowin(a_up_allowin), .dn_valid(a_dn_valid), .dn_bus(a_dn_bus),
        .dn_allowin(dn_allowin), .flush(flush), .count(a_count),
        .full(a_full), .empty(a_empty)
    );

    stage_buf #(.DATA_W(8), .DEPTH(3), .BYPASS(1'b0)) u_c (
        .clk(clk), .reset(reset), .up_valid(up_valid), .up_bus(up_bus),
        .up_allowin(c_up_allowin), .dn_valid(c_dn_valid), .dn_bus(c_dn_bus),
        .dn_allowin(dn_allowin), .flush(flush), .count(c_count),
        .full(c_full), .empty(c_empty)
    );

    stage_buf #(.DATA_W(8), .DEPTH(2), .BYPASS(1'b1)) u_b (
        .clk(clk), .reset(reset), .up_valid(up_valid), .up_bus(up_bus),
        .up_allowin(b_up_allowin), .dn_valid(b_dn_valid), .dn_bus(b_dn_bus),
        .dn_allowin(dn_allowin), .flush(flush), .count(b_count),
        .full(b_full), .empty(b_empty)
    );

    // Sweep instances: DEPTH 1, 2, 5, each with its own inputs.
    logic        s_flush = 1'b0;
    logic        s_up_valid [3];
    logic [15:0] s_up_bus [3];
    logic        s_dn_allowin [3];
    logic        s_up_allowin [3];
    logic        s_dn_valid [3];
    logic [15:0] s_dn_bus [3];
    logic        s_full [3];
    logic        s_empty [3];
    logic [0:0]  s1_cnt;
    logic [1:0]  s2_cnt;
    logic [2:0]  s5_cnt;
    logic [2:0]  s_cnt [3];

    assign s_cnt[0] = {2'b00, s1_cnt};
    assign s_cnt[1] = {1'b0, s2_cnt};
    assign s_cnt[2] = s5_cnt;

    stage_buf #(.DATA_W(16), .DEPTH(1)) u_s1 (
        .clk(clk), .reset(reset), .up_valid(s_up_valid[0]), .up_bus(s_up_bus[0]),
        .up_allowin(s_up_allowin[0]), .dn_valid(s_dn_valid[0]), .dn_bus(s_dn_bus[0]),
        .dn_allowin(s_dn_allowin[0]), .flush(s_flush), .count(s1_cnt),
        .full(s_full[0]), .empty(s_empty[0])
    );

    stage_buf #(.DATA_W(16), .DEPTH(2)) u_s2 (
        .clk(clk), .reset(reset), .up_valid(s_up_valid[1]), .up_bus(s_up_bus[1]),
        .up_allowin(s_up_allowin[1]), .dn_valid(s_dn_valid[1]), .dn_bus(s_dn_bus[1]),
        .dn_allowin(s_dn_allowin[1]), .flush(s_flush), .count(s2_cnt),
        .full(s_full[1]), .empty(s_empty[1])
    );

    stage_buf #(.DATA_W(16), .DEPTH(5)) u_s5 (
        .clk(clk), .reset(reset), .up_valid(s_up_valid[2]), .up_bus(s_up_bus[2]),
        .up_allowin(s_up_allowin[2]), .dn_valid(s_dn_valid[2]), .dn_bus(s_dn_bus[2]),
        .dn_allowin(s_dn_allowin[2]), .flush(s_flush), .count(s5_cnt),
        .full(s_full[2]), .empty(s_empty[2])
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        up_valid = 1'b0;
        up_bus = '0;
        dn_allowin = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_up_valid[k] = 1'b0;
            s_up_bus[k] = '0;
            s_dn_allowin[k] = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        up_valid = 1'b1;
        up_bus = 8'h77;
        dn_allowin = 1'b1;
        #1;
        n_checks++; if (a_count !== 2'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", a_count); end
        n_checks++; if (a_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got=%b exp=1", a_empty); end
        n_checks++; if (a_full !== 1'b0) begin n_errors++; $display("FAIL reset_full got=%b exp=0", a_full); end
        n_checks++; if (a_dn_valid !== 1'b0) begin n_errors++; $display("FAIL reset_dn_valid got=%b exp=0", a_dn_valid); end
        n_checks++; if (a_dn_bus !== 8'h00) begin n_errors++; $display("FAIL reset_dn_bus got=%h exp=00", a_dn_bus); end
        n_checks++; if (a_up_allowin !== 1'b1) begin n_errors++; $display("FAIL reset_up_allowin got=%b exp=1", a_up_allowin); end
        n_checks++; if (b_dn_valid !== 1'b0) begin n_errors++; $display("FAIL reset_bypass_dn_valid got=%b exp=0", b_dn_valid); end
        n_checks++; if (b_dn_bus !== 8'h00) begin n_errors++; $display("FAIL reset_bypass_dn_bus got=%h exp=00", b_dn_bus); end
        @(negedge clk);
        up_valid = 1'b0;
        dn_allowin = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_fill_drain();
        do_reset();
        up_valid = 1'b1;
        up_bus = 8'h0A;
        dn_allowin = 1'b0;
        #1;
        n_checks++; if (a_up_allowin !== 1'b1) begin n_errors++; $display("FAIL fd_allowin_empty got=%b exp=1", a_up_allowin); end
        n_checks++; if (a_dn_valid !== 1'b0) begin n_errors++; $display("FAIL fd_no_bypass got=%b exp=0", a_dn_valid); end
        @(negedge clk);
        up_bus = 8'h0B;
        #1;
        n_checks++; if (a_count !== 2'd1) begin n_errors++; $display("FAIL fd_count1 got=%0d exp=1", a_count); end
        n_checks++; if (a_dn_valid !== 1'b1) begin n_errors++; $display("FAIL fd_latency_valid got=%b exp=1", a_dn_valid); end
        n_checks++; if (a_dn_bus !== 8'h0A) begin n_errors++; $display("FAIL fd_latency_bus got=%h exp=0a", a_dn_bus); end
        @(negedge clk);
        up_bus = 8'hCC;
        #1;
        n_checks++; if (a_count !== 2'd2) begin n_errors++; $display("FAIL fd_count2 got=%0d exp=2", a_count); end
        n_checks++; if (a_full !== 1'b1) begin n_errors++; $display("FAIL fd_full got=%b exp=1", a_full); end
        n_checks++; if (a_up_allowin !== 1'b0) begin n_errors++; $display("FAIL fd_allowin_full got=%b exp=0", a_up_allowin); end
        @(negedge clk);
        up_valid = 1'b0;
        dn_allowin = 1'b1;
        #1;
        n_checks++; if (a_count !== 2'd2) begin n_errors++; $display("FAIL fd_ignored_push got=%0d exp=2", a_count); end
        n_checks++; if (a_dn_bus !== 8'h0A) begin n_errors++; $display("FAIL fd_pop1 got=%h exp=0a", a_dn_bus); end
        n_checks++; if (a_up_allowin !== 1'b1) begin n_errors++; $display("FAIL fd_allowin_pop got=%b exp=1", a_up_allowin); end
        @(negedge clk);
        #1;
        n_checks++; if (a_dn_bus !== 8'h0B) begin n_errors++; $display("FAIL fd_pop2 got=%h exp=0b", a_dn_bus); end
        n_checks++; if (a_count !== 2'd1) begin n_errors++; $display("FAIL fd_count_drain got=%0d exp=1", a_count); end
        @(negedge clk);
        dn_allowin = 1'b0;
        #1;
        n_checks++; if (a_empty !== 1'b1) begin n_errors++; $display("FAIL fd_empty got=%b exp=1", a_empty); end
        n_checks++; if (a_dn_valid !== 1'b0) begin n_errors++; $display("FAIL fd_dn_valid_end got=%b exp=0", a_dn_valid); end
        n_checks++; if (a_dn_bus !== 8'h00) begin n_errors++; $display("FAIL fd_dn_bus_end got=%h exp=00", a_dn_bus); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        up_valid = 1'b1;
        dn_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            up_bus = 8'(i + 1);
            @(negedge clk);
        end
        #1;
        n_checks++; if (c_full !== 1'b1) begin n_errors++; $display("FAIL fpp_full got=%b exp=1", c_full); end
        n_checks++; if (c_count !== 2'd3) begin n_errors++; $display("FAIL fpp_count got=%0d exp=3", c_count); end
        // Pushes 4,5,6 overlap pops 1,2,3; read pointer wraps 2->0 on the third pop.
        for (int i = 0; i < 6; i++) begin
            up_valid = (i < 3);
            up_bus = 8'(4 + i);
            dn_allowin = 1'b1;
            #1;
            n_checks++; if (c_dn_valid !== 1'b1) begin n_errors++; $display("FAIL fpp_valid[%0d] got=%b exp=1", i, c_dn_valid); end
            n_checks++; if (c_dn_bus !== 8'(i + 1)) begin n_errors++; $display("FAIL fpp_order[%0d] got=%h exp=%h", i, c_dn_bus, 8'(i + 1)); end
            n_checks++; if (c_count !== 2'((i < 4) ? 3 : 6 - i)) begin n_errors++; $display("FAIL fpp_count[%0d] got=%0d exp=%0d", i, c_count, (i < 4) ? 3 : 6 - i); end
            if (i < 3) begin
                n_checks++; if (c_up_allowin !== 1'b1) begin n_errors++; $display("FAIL fpp_allowin[%0d] got=%b exp=1", i, c_up_allowin); end
            end
            @(negedge clk);
        end
        up_valid = 1'b0;
        dn_allowin = 1'b0;
        #1;
        n_checks++; if (c_empty !== 1'b1) begin n_errors++; $display("FAIL fpp_empty got=%b exp=1", c_empty); end
        n_checks++; if (c_dn_valid !== 1'b0) begin n_errors++; $display("FAIL fpp_dn_valid_end got=%b exp=0", c_dn_valid); end
    endtask

    task automatic test_bypass();
        do_reset();
        up_valid = 1'b1;
        up_bus = 8'h55;
        dn_allowin = 1'b1;
        #1;
        n_checks++; if (b_dn_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid got=%b exp=1", b_dn_valid); end
        n_checks++; if (b_dn_bus !== 8'h55) begin n_errors++; $display("FAIL bp_bus got=%h exp=55", b_dn_bus); end
        n_checks++; if (b_count !== 2'd0) begin n_errors++; $display("FAIL bp_count got=%0d exp=0", b_count); end
        @(negedge clk);
        up_valid = 1'b0;
        #1;
        n_checks++; if (b_count !== 2'd0) begin n_errors++; $display("FAIL bp_not_stored got=%0d exp=0", b_count); end
        n_checks++; if (b_dn_valid !== 1'b0) begin n_errors++; $display("FAIL bp_idle_valid got=%b exp=0", b_dn_valid); end
        up_valid = 1'b1;
        up_bus = 8'h55;
        dn_allowin = 1'b0;
        #1;
        n_checks++; if (b_dn_valid !== 1'b1) begin n_errors++; $display("FAIL bp_stall_valid got=%b exp=1", b_dn_valid); end
        @(negedge clk);
        up_bus = 8'h66;
        #1;
        n_checks++; if (b_count !== 2'd1) begin n_errors++; $display("FAIL bp_stored got=%0d exp=1", b_count); end
        n_checks++; if (b_dn_bus !== 8'h55) begin n_errors++; $display("FAIL bp_head_not_input got=%h exp=55", b_dn_bus); end
        @(negedge clk);
        up_valid = 1'b0;
        dn_allowin = 1'b1;
        #1;
        n_checks++; if (b_count !== 2'd2) begin n_errors++; $display("FAIL bp_count2 got=%0d exp=2", b_count); end
        n_checks++; if (b_dn_bus !== 8'h55) begin n_errors++; $display("FAIL bp_pop1 got=%h exp=55", b_dn_bus); end
        @(negedge clk);
        #1;
        n_checks++; if (b_dn_bus !== 8'h66) begin n_errors++; $display("FAIL bp_pop2 got=%h exp=66", b_dn_bus); end
        @(negedge clk);
        dn_allowin = 1'b0;
        #1;
        n_checks++; if (b_empty !== 1'b1) begin n_errors++; $display("FAIL bp_empty got=%b exp=1", b_empty); end
    endtask

    task automatic test_flush();
        do_reset();
        up_valid = 1'b1;
        dn_allowin = 1'b0;
        up_bus = 8'h11;
        @(negedge clk);
        up_bus = 8'h22;
        @(negedge clk);
        flush = 1'b1;
        up_bus = 8'h33;
        dn_allowin = 1'b1;
        #1;
        n_checks++; if (a_count !== 2'd2) begin n_errors++; $display("FAIL fl_pre_count got=%0d exp=2", a_count); end
        n_checks++; if (a_dn_valid !== 1'b0) begin n_errors++; $display("FAIL fl_dn_valid got=%b exp=0", a_dn_valid); end
        n_checks++; if (a_up_allowin !== 1'b0) begin n_errors++; $display("FAIL fl_up_allowin got=%b exp=0", a_up_allowin); end
        @(negedge clk);
        flush = 1'b0;
        up_bus = 8'h44;
        dn_allowin = 1'b0;
        #1;
        n_checks++; if (a_count !== 2'd0) begin n_errors++; $display("FAIL fl_count got=%0d exp=0", a_count); end
        n_checks++; if (a_empty !== 1'b1) begin n_errors++; $display("FAIL fl_empty got=%b exp=1", a_empty); end
        @(negedge clk);
        up_valid = 1'b0;
        #1;
        n_checks++; if (a_count !== 2'd1) begin n_errors++; $display("FAIL fl_after_count got=%0d exp=1", a_count); end
        n_checks++; if (a_dn_bus !== 8'h44) begin n_errors++; $display("FAIL fl_after_bus got=%h exp=44", a_dn_bus); end
    endtask

    task automatic test_async_reset();
        do_reset();
        up_valid = 1'b1;
        dn_allowin = 1'b0;
        up_bus = 8'hA1;
        @(negedge clk);
        up_bus = 8'hA2;
        @(negedge clk);
        up_valid = 1'b0;
        #1;
        n_checks++; if (a_count !== 2'd2) begin n_errors++; $display("FAIL ar_pre_count got=%0d exp=2", a_count); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (a_count !== 2'd0) begin n_errors++; $display("FAIL ar_count got=%0d exp=0", a_count); end
        n_checks++; if (a_dn_valid !== 1'b0) begin n_errors++; $display("FAIL ar_dn_valid got=%b exp=0", a_dn_valid); end
        n_checks++; if (a_empty !== 1'b1) begin n_errors++; $display("FAIL ar_empty got=%b exp=1", a_empty); end
        @(negedge clk);
        reset = 1'b0;
        up_valid = 1'b1;
        up_bus = 8'h99;
        @(negedge clk);
        up_valid = 1'b0;
        #1;
        n_checks++; if (a_count !== 2'd1) begin n_errors++; $display("FAIL ar_first_edge_count got=%0d exp=1", a_count); end
        n_checks++; if (a_dn_bus !== 8'h99) begin n_errors++; $display("FAIL ar_first_edge_bus got=%h exp=99", a_dn_bus); end
    endtask

    task automatic test_sweep(input int k, input int depth);
        logic [15:0] exp_q[$];
        logic [15:0] seq;
        int model_cnt;
        int up_thr;
        int dn_thr;
        bit hold;
        bit exp_allow;
        bit push;
        bit pop;
        do_reset();
        exp_q.delete();
        seq = 16'h0001;
        hold = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            case (i / 2500)
                0:       begin up_thr = 3; dn_thr = 1; end
                1:       begin up_thr = 2; dn_thr = 2; end
                2:       begin up_thr = 1; dn_thr = 3; end
                default: begin up_thr = 2; dn_thr = 2; end
            endcase
            if (!hold) begin
                s_up_valid[k] = ($urandom_range(0, 3) < up_thr);
                s_up_bus[k] = seq;
            end
            s_dn_allowin[k] = ($urandom_range(0, 3) < dn_thr);
            #1;
            model_cnt = exp_q.size();
            exp_allow = (model_cnt < depth) || s_dn_allowin[k];
            n_checks++; if (s_cnt[k] !== 3'(model_cnt)) begin n_errors++; $display("FAIL sw%0d_count cyc=%0d got=%0d exp=%0d", depth, i, s_cnt[k], model_cnt); end
            n_checks++; if (32'(s_cnt[k]) > depth) begin n_errors++; $display("FAIL sw%0d_bound cyc=%0d got=%0d max=%0d", depth, i, s_cnt[k], depth); end
            n_checks++; if (s_full[k] !== (model_cnt == depth)) begin n_errors++; $display("FAIL sw%0d_full cyc=%0d got=%b", depth, i, s_full[k]); end
            n_checks++; if (s_empty[k] !== (model_cnt == 0)) begin n_errors++; $display("FAIL sw%0d_empty cyc=%0d got=%b", depth, i, s_empty[k]); end
            n_checks++; if (s_up_allowin[k] !== exp_allow) begin n_errors++; $display("FAIL sw%0d_allowin cyc=%0d got=%b exp=%b", depth, i, s_up_allowin[k], exp_allow); end
            n_checks++; if (s_dn_valid[k] !== (model_cnt > 0)) begin n_errors++; $display("FAIL sw%0d_dn_valid cyc=%0d got=%b exp=%b", depth, i, s_dn_valid[k], model_cnt > 0); end
            if (model_cnt > 0) begin
                n_checks++; if (s_dn_bus[k] !== exp_q[0]) begin n_errors++; $display("FAIL sw%0d_data cyc=%0d got=%h exp=%h", depth, i, s_dn_bus[k], exp_q[0]); end
            end
            push = s_up_valid[k] && exp_allow;
            pop = (model_cnt > 0) && s_dn_allowin[k];
            @(posedge clk);
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                exp_q.push_back(s_up_bus[k]);
                seq = seq + 16'd1;
            end
            hold = s_up_valid[k] && !push;
            @(negedge clk);
        end
        s_up_valid[k] = 1'b0;
        s_dn_allowin[k] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            s_up_valid[k] = 1'b0;
            s_up_bus[k] = '0;
            s_dn_allowin[k] = 1'b0;
        end
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_bypass();
        test_flush();
        test_async_reset();
        test_sweep(0, 1);
        test_sweep(1, 2);
        test_sweep(2, 5);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stage_buf.md
STAGE_BUF -- requirements
Module: stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of the stage bus carried per entry.
REQ-002 SHALL have parameter DEPTH, default 2: entry count; legal range 1..16; need not be a power of 2.
REQ-003 SHALL have parameter BYPASS, default 0: 1 enables same-cycle pass-through when empty.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port up_valid  input  1  upstream stage presents a valid bus.
REQ-007 SHALL have port up_bus  input  DATA_W  upstream stage bus.
REQ-008 SHALL have port up_allowin  output  1  buffer accepts up_bus this cycle.
REQ-009 SHALL have port dn_valid  output  1  head entry, or bypassed input, valid to downstream.
REQ-010 SHALL have port dn_bus  output  DATA_W  head entry, or bypassed input.
REQ-011 SHALL have port dn_allowin  input  1  downstream accepts dn_bus this cycle.
REQ-012 SHALL have port flush  input  1  writeback-stage refresh: discard all contents.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of stored entries.
REQ-014 SHALL have ports full and empty  output  1 each: count==DEPTH and count==0 respectively.

Function
REQ-015 SHALL define push as up_valid && up_allowin, and pop as dn_valid && dn_allowin && entry-sourced, where entry-sourced means the buffer is not empty.
REQ-016 SHALL drive up_allowin = !flush && (!full || dn_allowin), so a push into a full buffer is allowed in the same cycle as a pop.
REQ-017 With BYPASS=0, SHALL drive dn_valid = !empty && !flush, and dn_bus = head entry when dn_valid, else all-zero.
REQ-018 With BYPASS=1 and the buffer empty, SHALL drive dn_valid = up_valid && !flush and dn_bus = up_bus.
REQ-019 With BYPASS=1, if the buffer is empty, up_valid=1 and dn_allowin=1, the data SHALL pass straight through, nothing SHALL be stored, and count SHALL be unchanged.
REQ-020 With BYPASS=1 and the buffer not empty, behaviour SHALL be identical to BYPASS=0, so ordering is preserved.
REQ-021 SHALL preserve strict FIFO order; the write pointer and read pointer each wrap from DEPTH-1 to 0.
REQ-022 On push without pop, count SHALL increase by 1; on pop without push, count SHALL decrease by 1; on push with pop, count SHALL be unchanged and the pointers SHALL both advance.
REQ-023 Latency with BYPASS=0: data pushed at edge n SHALL be visible on dn_bus with dn_valid=1 from edge n onward if the buffer was empty, i.e. 1 cycle after up_valid was presented.
REQ-024 SHALL never overflow or underflow; up_valid presented while up_allowin=0 SHALL be ignored, and upstream holds the data.
REQ-025 flush=1 at an edge SHALL leave count=0 and both pointers=0 after that edge.
REQ-026 Any push or pop in a flush cycle SHALL be suppressed.
REQ-027 flush SHALL force dn_valid=0 and up_allowin=0 combinationally in the flush cycle.
REQ-028 Stored data SHALL not change except on push; storage need not be reset.
REQ-029 No combinational path SHALL exist from up_valid or up_bus to up_allowin.
REQ-030 The only combinational dependency of up_allowin SHALL be dn_allowin → up_allowin.

Reset
REQ-031 While reset=1, SHALL asynchronously force count=0, both pointers=0, empty=1, full=0, dn_valid=0 and dn_bus=0.
REQ-032 While reset=1, up_allowin SHALL be 1.
REQ-033 A reset asserted mid-operation SHALL discard all entries, with no partial push or pop.
REQ-034 After reset deasserts, the first rising edge SHALL operate normally.

Verification
REQ-035 Fill/drain, DEPTH=2, BYPASS=0, dn_allowin=0: push 0xA then 0xB → count=2, full=1, up_allowin=0.
REQ-036 Continuing REQ-035, raise dn_allowin → pops 0xA then 0xB in order, then empty=1, dn_valid=0, dn_bus=0.
REQ-037 Full with simultaneous push/pop, DEPTH=3: buffer full with 1,2,3, dn_allowin=1, push 4 → pop 1, count stays 3, contents 2,3,4.
REQ-038 Continuing REQ-037, cover pointer wrap at index 2→0.
REQ-039 Bypass, BYPASS=1, empty, up_valid=1, up_bus=0x55, dn_allowin=1 → same cycle dn_valid=1, dn_bus=0x55, count remains 0.
REQ-040 Bypass, continuing REQ-039, with dn_allowin=0 instead → 0x55 stored, count=1 next cycle.
REQ-041 Flush: 2 entries stored, flush=1 with up_valid=1 → in that cycle dn_valid=0 and up_allowin=0; next cycle count=0, empty=1, and the new data is not stored.
REQ-042 Async reset: assert reset between edges with count=2 → count=0 and dn_valid=0 immediately, without a clock edge.
REQ-043 Backpressure sweep: random up_valid and dn_allowin for 10k cycles, DEPTH ∈ {1,2,5} → scoreboard shows no loss, duplication or reordering, and count always ≤ DEPTH.
